input_port_vc_buffer: RTL and testbench
=======================================

Name: input_port_vc_buffer

Overview:
Per-input-port buffering stage that sits directly upstream of the separable input-first switch allocator. It holds one FIFO per VC and runs a per-VC packet state machine. XY route computation is performed on head flits. It drives one row of the allocator's request and out-port inputs, then pops and forwards the granted flit toward the crossbar.

Parameters:
VC_NUM, 2, virtual channels per input port (must match the allocator).
BUFFER_SIZE, 8, flit depth per VC FIFO (power of 2, >=2).
X_CURRENT, 0, this router's mesh X coordinate.
Y_CURRENT, 0, this router's mesh Y coordinate.

Ports:
clk  in  1  clock.
rst  in  1  asynchronous active-high reset.
data_i  in  flit_t  incoming flit. Its vc_id field selects the target VC.
valid_flit_i  in  1  data_i valid this cycle.
sa_grant_i  in  VC_NUM  allocator grant for this port, at most one bit set.
request_o  out  VC_NUM  per-VC switch request to the allocator.
out_port_o  out  port_t[VC_NUM]  per-VC routed output port.
flit_o  out  flit_t  popped flit, sent toward the crossbar.
valid_flit_o  out  1  flit_o valid.
is_full_o  out  VC_NUM  per-VC FIFO full.
is_empty_o  out  VC_NUM  per-VC FIFO empty.
overflow_o  out  1  sticky: a write was made to a full VC with no pop.

Behaviour:
- Reset (async, rst=1):
  - All FIFOs are flushed and all pointers zeroed.
  - Every VC state is IDLE.
  - request_o=0, out_port_o[*]=LOCAL, valid_flit_o=0, flit_o='0.
  - is_empty_o=all 1, is_full_o=0, overflow_o=0.
  - A reset mid-packet discards all buffered flits; there is no partial drain.
- Write:
  - On posedge with valid_flit_i, data_i is pushed to FIFO[data_i.vc_id].
  - If that VC is full and is not popped in the same cycle, the flit is dropped and overflow_o is set (it clears only on reset).
  - A write to a full VC in the same cycle that VC is popped is accepted, leaving the count unchanged.
- Per-VC FSM:
  - IDLE → RC when the FIFO head is HEAD or HEADTAIL.
  - RC takes one cycle: the route is computed from the head's dest_x/dest_y, registered into out_port_o[v], and the VC moves to ACTIVE.
  - ACTIVE: request_o[v] = !is_empty_o[v].
  - Pop of TAIL or HEADTAIL in ACTIVE → IDLE; out_port_o[v] is held until the next RC.
  - A BODY or TAIL flit at the head while IDLE is a protocol error: the flit is held and the VC never requests.
- Route (XY):
  - dest_x > X_CURRENT → EAST; dest_x < X_CURRENT → WEST.
  - Otherwise dest_y > Y_CURRENT → SOUTH; dest_y < Y_CURRENT → NORTH.
  - Otherwise LOCAL.
- Grant and pop:
  - The allocator is combinational: sa_grant_i sampled at posedge t answers request_o in cycle t.
  - The granted VC's head is popped at posedge t; flit_o/valid_flit_o are registered and valid in cycle t+1 for exactly one cycle.
  - A grant to a VC with request_o low is ignored.
  - More than one grant bit set is illegal: the lowest index wins and an assertion fires.
- Pointers wrap modulo BUFFER_SIZE. Count width is $clog2(BUFFER_SIZE)+1.
- request_o for a VC drops in the cycle after its last flit is popped. With a pop and a push on the same cycle the request stays high.

Optional Feature:
Macro VC_CREDIT_RETURN_EN.
- Defined: adds output credit_o [VC_NUM], registered. Bit v pulses high for exactly one cycle, at t+1, for each pop of VC v at posedge t, so the upstream router can count credits. Drops due to overflow do not generate credits.
- Undefined: the port is absent and no credit logic is built.

Decomposition:
- noc_params holds the following shared definitions:
  - port_t (LOCAL, NORTH, SOUTH, WEST, EAST) and PORT_NUM.
  - flit_label_t (HEAD, BODY, TAIL, HEADTAIL).
  - flit_t with fields flit_label, vc_id, dest_x, dest_y, data.
  - DEST_ADDR_SIZE_X/Y.
- One sub-module, input_vc_fifo: a single-VC circular buffer with push/pop, full/empty and head-flit peek, instantiated VC_NUM times.
- The FSM, route computation and output mux live in the top.

Test Plan:
- Reset → request_o=00, is_empty_o=11, valid_flit_o=0, out_port_o all LOCAL. Assert rst mid-packet → same values next cycle.
- X/Y=(1,1); push HEAD (dest 3,1)+BODY+TAIL on VC0; grant VC0 every cycle → out_port_o[0]=EAST at RC+1, flits out in order at t+1, VC0 back to IDLE, request_o[0]=0.
- HEADTAIL dest (1,0) on VC1 → out_port_o[1]=NORTH, single grant → one flit out, VC1 IDLE. Dest (1,1) → LOCAL.
- Fill VC0 with 8 flits → is_full_o[0]=1; 9th write with no grant → overflow_o=1, count 8. 9th write with simultaneous grant → accepted, no overflow.
- Both VCs active; alternate grants 01,10 → interleaved output, each VC's packet order preserved; grant with request low → no valid_flit_o.
- With VC_CREDIT_RETURN_EN defined: 3 pops of VC1 → three single-cycle credit_o[1] pulses at t+1; dropped overflow flit → no pulse.

Source files
------------

// File: rtl/noc_params.sv
// Shared NoC definitions: output ports, flit labels, flit layout and the XY route helper.
package noc_params;

  localparam int DEST_ADDR_SIZE_X = 4;
  localparam int DEST_ADDR_SIZE_Y = 4;
  localparam int VC_SIZE          = 1;
  localparam int FLIT_DATA_SIZE   = 16;
  localparam int PORT_NUM         = 5;

  typedef enum logic [2:0] {LOCAL, NORTH, SOUTH, WEST, EAST} port_t;

  typedef enum logic [1:0] {HEAD, BODY, TAIL, HEADTAIL} flit_label_t;

  typedef struct packed {
    flit_label_t                 flit_label;
    logic [VC_SIZE-1:0]          vc_id;
    logic [DEST_ADDR_SIZE_X-1:0] dest_x;
    logic [DEST_ADDR_SIZE_Y-1:0] dest_y;
    logic [FLIT_DATA_SIZE-1:0]   data;
  } flit_t;

  typedef enum logic [1:0] {VC_IDLE, VC_RC, VC_ACTIVE} vc_state_t;

  // Dimension-ordered routing: resolve X fully before Y.
  function automatic port_t xy_route(input logic [DEST_ADDR_SIZE_X-1:0] dest_x,
                                     input logic [DEST_ADDR_SIZE_Y-1:0] dest_y,
                                     input int x_cur, input int y_cur);
    port_t p;
    if (int'(dest_x) > x_cur)      p = EAST;
    else if (int'(dest_x) < x_cur) p = WEST;
    else if (int'(dest_y) > y_cur) p = SOUTH;
    else if (int'(dest_y) < y_cur) p = NORTH;
    else                           p = LOCAL;
    return p;
  endfunction

endpackage

// File: rtl/input_vc_fifo.sv
// Single-VC circular flit buffer with head peek; a push into a full buffer is
// accepted only when a pop happens on the same edge, otherwise it is dropped.
module input_vc_fifo
  import noc_params::*;
#(
  parameter int BUFFER_SIZE = 8
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  i_push,
  input  flit_t i_dat,
  input  logic  i_pop,
  output flit_t o_head,
  output logic  o_full,
  output logic  o_empty,
  output logic  o_drop
);

  localparam int PTR_W = $clog2(BUFFER_SIZE);
  localparam int CNT_W = PTR_W + 1;

  flit_t            r_mem [BUFFER_SIZE];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CNT_W'(BUFFER_SIZE));
  assign o_empty   = (r_count == '0);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_drop    = i_push && o_full && !w_do_pop;
  assign o_head    = r_mem[r_rd_ptr];

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_dat;
  end

endmodule

// File: rtl/input_port_vc_buffer.sv
// Input port stage: per-VC FIFOs, per-VC IDLE/RC/ACTIVE packet FSM with XY routing, granted-flit pop.
// Define VC_CREDIT_RETURN_EN to add the registered per-VC credit_o pop pulses.
module input_port_vc_buffer
  import noc_params::*;
#(
  parameter int VC_NUM      = 2,
  parameter int BUFFER_SIZE = 8,
  parameter int X_CURRENT   = 0,
  parameter int Y_CURRENT   = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  flit_t                    data_i,
  input  logic                     valid_flit_i,
  input  logic [VC_NUM-1:0]        sa_grant_i,
  output logic [VC_NUM-1:0]        request_o,
  output port_t [VC_NUM-1:0]       out_port_o,
  output flit_t                    flit_o,
  output logic                     valid_flit_o,
  output logic [VC_NUM-1:0]        is_full_o,
  output logic [VC_NUM-1:0]        is_empty_o,
  output logic                     overflow_o
`ifdef VC_CREDIT_RETURN_EN
  ,
  output logic [VC_NUM-1:0]        credit_o
`endif
);

  vc_state_t [VC_NUM-1:0] r_state;
  vc_state_t [VC_NUM-1:0] w_state_nxt;
  port_t     [VC_NUM-1:0] r_out_port;
  flit_t                  w_head [VC_NUM];
  logic      [VC_NUM-1:0] w_push;
  logic      [VC_NUM-1:0] w_drop;
  logic      [VC_NUM-1:0] w_grant_sel;
  logic      [VC_NUM-1:0] w_pop;
  flit_t                  w_pop_flit;
  flit_t                  r_flit;
  logic                   r_valid;
  logic                   r_overflow;

  for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
    assign w_push[v] = valid_flit_i && (int'(data_i.vc_id) == v);

    input_vc_fifo #(.BUFFER_SIZE(BUFFER_SIZE)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push[v]),
      .i_dat   (data_i),
      .i_pop   (w_pop[v]),
      .o_head  (w_head[v]),
      .o_full  (is_full_o[v]),
      .o_empty (is_empty_o[v]),
      .o_drop  (w_drop[v])
    );
  end

  // Lowest set grant bit wins; a grant to a non-requesting VC pops nothing.
  assign w_grant_sel = sa_grant_i & (~sa_grant_i + 1'b1);
  assign w_pop       = w_grant_sel & request_o;

  always_comb begin
    w_pop_flit = '0;
    for (int v = 0; v < VC_NUM; v++) begin
      if (w_pop[v]) w_pop_flit = w_head[v];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int v = 0; v < VC_NUM; v++) r_state[v] <= VC_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A BODY/TAIL head while idle never leaves IDLE, so that VC stalls for good.
  always_comb begin
    w_state_nxt = r_state;
    for (int v = 0; v < VC_NUM; v++) begin
      case (r_state[v])
        VC_IDLE:
          if (!is_empty_o[v] &&
              (w_head[v].flit_label == HEAD || w_head[v].flit_label == HEADTAIL))
            w_state_nxt[v] = VC_RC;
        VC_RC:
          w_state_nxt[v] = VC_ACTIVE;
        VC_ACTIVE:
          if (w_pop[v] &&
              (w_head[v].flit_label == TAIL || w_head[v].flit_label == HEADTAIL))
            w_state_nxt[v] = VC_IDLE;
        default:
          w_state_nxt[v] = VC_IDLE;
      endcase
    end
  end

  always_comb begin
    request_o = '0;
    for (int v = 0; v < VC_NUM; v++) begin
      request_o[v] = (r_state[v] == VC_ACTIVE) && !is_empty_o[v];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int v = 0; v < VC_NUM; v++) r_out_port[v] <= LOCAL;
      r_flit     <= '0;
      r_valid    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      for (int v = 0; v < VC_NUM; v++) begin
        if (r_state[v] == VC_RC)
          r_out_port[v] <= xy_route(w_head[v].dest_x, w_head[v].dest_y, X_CURRENT, Y_CURRENT);
      end
      if (|w_pop) r_flit <= w_pop_flit;
      r_valid    <= |w_pop;
      r_overflow <= r_overflow | (|w_drop);
    end
  end

  assign out_port_o   = r_out_port;
  assign flit_o       = r_flit;
  assign valid_flit_o = r_valid;
  assign overflow_o   = r_overflow;

`ifdef VC_CREDIT_RETURN_EN
  logic [VC_NUM-1:0] r_credit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_credit <= '0;
    else     r_credit <= w_pop;
  end

  assign credit_o = r_credit;
`endif

  a_grant_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(sa_grant_i));

endmodule

// File: tb/tb_input_port_vc_buffer.sv
// Directed bench for input_port_vc_buffer at router (1,1) with a queue-based reference model.
module tb_input_port_vc_buffer;
  import noc_params::*;

  localparam int VCN = 2;
  localparam int BUF = 8;
  localparam int XC  = 1;
  localparam int YC  = 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  flit_t            data_i = '0;
  logic             valid_flit_i = 1'b0;
  logic [VCN-1:0]   sa_grant_i = '0;
  logic [VCN-1:0]   request_o;
  port_t [VCN-1:0]  out_port_o;
  flit_t            flit_o;
  logic             valid_flit_o;
  logic [VCN-1:0]   is_full_o;
  logic [VCN-1:0]   is_empty_o;
  logic             overflow_o;
`ifdef VC_CREDIT_RETURN_EN
  logic [VCN-1:0]   credit_o;
  int               cred1_cnt = 0;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  input_port_vc_buffer #(
    .VC_NUM(VCN), .BUFFER_SIZE(BUF), .X_CURRENT(XC), .Y_CURRENT(YC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .data_i       (data_i),
    .valid_flit_i (valid_flit_i),
    .sa_grant_i   (sa_grant_i),
    .request_o    (request_o),
    .out_port_o   (out_port_o),
    .flit_o       (flit_o),
    .valid_flit_o (valid_flit_o),
    .is_full_o    (is_full_o),
    .is_empty_o   (is_empty_o),
    .overflow_o   (overflow_o)
`ifdef VC_CREDIT_RETURN_EN
    ,
    .credit_o     (credit_o)
`endif
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h time=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a queue per VC plus a packet phase (0 waiting, 1 routing, 2 forwarding).
  flit_t          mq [VCN][$];
  int             m_mode [VCN] = '{default: 0};
  port_t          m_port [VCN] = '{default: LOCAL};
  logic           m_vld = 1'b0;
  logic           m_ovf = 1'b0;
  flit_t          m_flit = '0;
  logic [VCN-1:0] m_cred = '0;
  logic [15:0]    out_log [$];

  function automatic port_t route(input flit_t f);
    if (int'(f.dest_x) > XC) return EAST;
    if (int'(f.dest_x) < XC) return WEST;
    if (int'(f.dest_y) > YC) return SOUTH;
    if (int'(f.dest_y) < YC) return NORTH;
    return LOCAL;
  endfunction

  always @(posedge clk or posedge rst) begin : mdl
    int    g;
    int    wv;
    bit    pop;
    bit    was_full;
    flit_t pf;
    if (rst) begin
      for (int v = 0; v < VCN; v++) begin
        mq[v].delete();
        m_mode[v] = 0;
        m_port[v] = LOCAL;
      end
      m_vld = 1'b0; m_ovf = 1'b0; m_flit = '0; m_cred = '0;
    end else begin
      g = -1;
      for (int v = VCN - 1; v >= 0; v--) if (sa_grant_i[v]) g = v;
      pop = (g >= 0) && (m_mode[g] == 2) && (mq[g].size() > 0);
      wv = int'(data_i.vc_id);
      was_full = valid_flit_i && (mq[wv].size() == BUF);
      for (int v = 0; v < VCN; v++) begin
        if (m_mode[v] == 0 && mq[v].size() > 0 &&
            (mq[v][0].flit_label == HEAD || mq[v][0].flit_label == HEADTAIL)) m_mode[v] = 1;
        else if (m_mode[v] == 1) begin
          m_port[v] = route(mq[v][0]);
          m_mode[v] = 2;
        end
      end
      m_cred = '0;
      if (pop) begin
        pf = mq[g].pop_front();
        m_flit = pf;
        m_cred[g] = 1'b1;
        if (pf.flit_label == TAIL || pf.flit_label == HEADTAIL) m_mode[g] = 0;
      end
      m_vld = pop;
      if (valid_flit_i) begin
        if (was_full && !(pop && g == wv)) m_ovf = 1'b1;
        else mq[wv].push_back(data_i);
      end
    end
  end

  always @(posedge clk) begin : cmp
    logic [VCN-1:0] e_req, e_emp, e_full;
    #2;
    for (int v = 0; v < VCN; v++) begin
      e_req[v]  = (m_mode[v] == 2) && (mq[v].size() > 0);
      e_emp[v]  = (mq[v].size() == 0);
      e_full[v] = (mq[v].size() == BUF);
    end
    chk("request", 64'(request_o), 64'(e_req));
    chk("empty", 64'(is_empty_o), 64'(e_emp));
    chk("full", 64'(is_full_o), 64'(e_full));
    chk("overflow", 64'(overflow_o), 64'(m_ovf));
    chk("valid", 64'(valid_flit_o), 64'(m_vld));
    chk("out_port", 64'(out_port_o), 64'({m_port[1], m_port[0]}));
    if (m_vld) chk("flit", 64'(flit_o), 64'(m_flit));
    if (valid_flit_o) out_log.push_back(flit_o.data);
`ifdef VC_CREDIT_RETURN_EN
    chk("credit", 64'(credit_o), 64'(m_cred));
    if (credit_o[1]) cred1_cnt++;
`endif
  end

  function automatic flit_t mk(input flit_label_t l, input int vc, input int dx, input int dy, input int d);
    flit_t f;
    f.flit_label = l;
    f.vc_id      = vc[0];
    f.dest_x     = dx[3:0];
    f.dest_y     = dy[3:0];
    f.data       = d[15:0];
    return f;
  endfunction

  task automatic cyc(input logic vld, input flit_t f, input logic [VCN-1:0] g);
    valid_flit_i = vld;
    data_i       = f;
    sa_grant_i   = g;
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic [VCN-1:0] g);
    repeat (n) cyc(1'b0, '0, g);
  endtask

  task automatic chk_idle_reset(input string nm);
    chk({nm, "_req"}, 64'(request_o), 64'h0);
    chk({nm, "_empty"}, 64'(is_empty_o), 64'h3);
    chk({nm, "_full"}, 64'(is_full_o), 64'h0);
    chk({nm, "_valid"}, 64'(valid_flit_o), 64'h0);
    chk({nm, "_ovf"}, 64'(overflow_o), 64'h0);
    chk({nm, "_port"}, 64'(out_port_o), 64'({LOCAL, LOCAL}));
  endtask

  typedef struct { int dx; int dy; port_t p; } rt_vec_t;
  rt_vec_t rt_tab [3] = '{'{1, 1, LOCAL}, '{0, 1, WEST}, '{1, 2, SOUTH}};

  initial begin
    flit_label_t lb;
    repeat (2) @(negedge clk);
    chk_idle_reset("reset");
    chk("reset_flit", 64'(flit_o), 64'h0);
    rst = 1'b0;

    // Three-flit packet east on VC0, grant held on VC0.
    cyc(1'b1, mk(HEAD, 0, 3, 1, 'hA1), 2'b01);
    cyc(1'b1, mk(BODY, 0, 3, 1, 'hA2), 2'b01);
    cyc(1'b1, mk(TAIL, 0, 3, 1, 'hA3), 2'b01);
    idle(8, 2'b01);
    chk("east_port", 64'(out_port_o[0]), 64'(EAST));
    chk("east_cnt", 64'(out_log.size()), 64'd3);
    chk("east_order", {16'h0, out_log[0], out_log[1], out_log[2]}, 64'h00A1_00A2_00A3);
    chk("east_req", 64'(request_o), 64'h0);
    out_log.delete();

    // Single-flit packet north on VC1, then a table of other destinations.
    cyc(1'b1, mk(HEADTAIL, 1, 1, 0, 'hB1), 2'b10);
    idle(6, 2'b10);
    chk("north_port", 64'(out_port_o[1]), 64'(NORTH));
    chk("north_cnt", 64'(out_log.size()), 64'd1);
    chk("north_data", 64'(out_log[0]), 64'h00B1);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, mk(HEADTAIL, 1, rt_tab[i].dx, rt_tab[i].dy, 'hB2 + i), 2'b10);
      idle(5, 2'b10);
      chk("route_tab", 64'(out_port_o[1]), 64'(rt_tab[i].p));
    end
    out_log.delete();

    // Fill VC0, then overflow with no pop.
    for (int i = 0; i < BUF; i++) begin
      lb = (i == 0) ? HEAD : BODY;
      cyc(1'b1, mk(lb, 0, 3, 1, 'hC0 + i), 2'b00);
    end
    chk("fill_full", 64'(is_full_o), 64'h1);
    chk("fill_no_ovf", 64'(overflow_o), 64'h0);
    cyc(1'b1, mk(BODY, 0, 3, 1, 'hC8), 2'b00);
    chk("drop_ovf", 64'(overflow_o), 64'h1);
    chk("drop_full", 64'(is_full_o), 64'h1);
    idle(2, 2'b00);
    chk("stalled_req", 64'(request_o), 64'h1);

    // Reset mid-packet discards everything.
    rst = 1'b1;
    @(negedge clk);
    chk_idle_reset("midrst");
    rst = 1'b0;

    // Refill, then write into the full VC while it is popped.
    for (int i = 0; i < BUF; i++) begin
      lb = (i == 0) ? HEAD : BODY;
      cyc(1'b1, mk(lb, 0, 3, 1, 'hD0 + i), 2'b00);
    end
    cyc(1'b1, mk(BODY, 0, 3, 1, 'hD8), 2'b01);
    chk("popwr_ovf", 64'(overflow_o), 64'h0);
    chk("popwr_full", 64'(is_full_o), 64'h1);
    cyc(1'b1, mk(TAIL, 0, 3, 1, 'hD9), 2'b01);
    idle(12, 2'b01);
    chk("drain_cnt", 64'(out_log.size()), 64'd10);
    chk("drain_last", 64'(out_log[9]), 64'h00D9);
    chk("drain_empty", 64'(is_empty_o), 64'h3);
    out_log.delete();

    // Both VCs active, alternating grants.
`ifdef VC_CREDIT_RETURN_EN
    cred1_cnt = 0;
`endif
    cyc(1'b1, mk(HEAD, 0, 2, 1, 'hE0), 2'b00);
    cyc(1'b1, mk(HEAD, 1, 1, 2, 'hF0), 2'b00);
    cyc(1'b1, mk(BODY, 0, 2, 1, 'hE1), 2'b00);
    cyc(1'b1, mk(BODY, 1, 1, 2, 'hF1), 2'b00);
    cyc(1'b1, mk(TAIL, 0, 2, 1, 'hE2), 2'b00);
    cyc(1'b1, mk(TAIL, 1, 1, 2, 'hF2), 2'b00);
    idle(1, 2'b00);
    chk("both_req", 64'(request_o), 64'h3);
    for (int i = 0; i < 3; i++) begin
      idle(1, 2'b01);
      idle(1, 2'b10);
    end
    idle(2, 2'b00);
    chk("ilv_cnt", 64'(out_log.size()), 64'd6);
    chk("ilv_order_a", {16'h0, out_log[0], out_log[1], out_log[2]}, 64'h00E0_00F0_00E1);
    chk("ilv_order_b", {16'h0, out_log[3], out_log[4], out_log[5]}, 64'h00F1_00E2_00F2);
    chk("ilv_ports", 64'(out_port_o), 64'({SOUTH, EAST}));
    idle(1, 2'b01);
    chk("nogrant_valid", 64'(valid_flit_o), 64'h0);
`ifdef VC_CREDIT_RETURN_EN
    chk("credit_vc1_pulses", 64'(cred1_cnt), 64'd3);
`endif
    idle(2, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
